// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer predictor.
package btb_predictor_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned PC_OFF_W    = 2;
  localparam int unsigned DEF_S_INDEX = 4;

  // Top-level control: normal lookup/update, or a sequential invalidate sweep.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } btb_state_e;

  // Two-bit saturating direction counter; bit 1 is the taken prediction.
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;
  localparam ctr_t CTR_ALLOC = 2'b10;
  localparam ctr_t CTR_MAX   = 2'b11;
  localparam ctr_t CTR_MIN   = 2'b00;

  // Saturating step of the direction counter toward the resolved outcome.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    if (taken) begin
      r = (c == CTR_MAX) ? CTR_MAX : c + 2'b01;
    end else begin
      r = (c == CTR_MIN) ? CTR_MIN : c - 2'b01;
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch lookup, execute update and flush signals of the BTB predictor.
interface btb_predictor_if;

  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_req;
  logic        flush_busy;

  // Pipeline side: drives fetch PC, resolved branches and flush requests.
  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_req,
    input  pred_hit, pred_taken, pred_target, flush_busy
  );

  // Predictor side.
  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_req,
    output pred_hit, pred_taken, pred_target, flush_busy
  );

endinterface

// File: rtl/btb_array.sv
// Branch target storage: one synchronous write port, one combinational read
// port. Contents are deliberately not reset; the valid bits in the predictor
// decide whether a slot means anything.
module btb_array #(
  parameter int width   = 32,
  parameter int s_index = 4
) (
  input  logic               clk,
  input  logic               load,
  input  logic [s_index-1:0] windex,
  input  logic [s_index-1:0] rindex,
  input  logic [width-1:0]   datain,
  output logic [width-1:0]   dataout
);

  logic [width-1:0] data [2**s_index];

  // Write the resolved target into the addressed slot.
  always_ff @(posedge clk) begin
    if (load) begin
      data[windex] <= datain;
    end
  end

  assign dataout = data[rindex];

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// zero-latency lookup, a one-deep update register with write-through
// forwarding, and a one-entry-per-cycle flush sweep.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int s_index = DEF_S_INDEX,
  parameter int s_tag   = PC_W - PC_OFF_W - s_index
) (
  input  logic            clk,
  input  logic            rst_n,
  btb_predictor_if.slave  bus
);

  localparam int   ENTRIES  = 2**s_index;
  localparam int   WORD_W   = PC_W - PC_OFF_W;

  typedef logic [s_index-1:0] idx_t;
  typedef logic [s_tag-1:0]   tag_t;

  localparam idx_t IDX_LAST = idx_t'(ENTRIES - 1);

  btb_state_e        state;
  btb_state_e        state_nx;
  idx_t              cnt;
  idx_t              cnt_nx;

  logic [ENTRIES-1:0] valid;
  tag_t               tags [ENTRIES];
  ctr_t               ctrs [ENTRIES];

  // Update register: word address of the branch, outcome and target.
  logic               pend_valid;
  logic [WORD_W-1:0]  pend_word;
  logic               pend_taken;
  logic [31:0]        pend_target;

  idx_t        ridx;
  tag_t        rtag;
  idx_t        widx;
  tag_t        wtag;
  logic [31:0] rd_target;

  logic        we;
  logic        w_hit;
  ctr_t        n_ctr;
  logic        arr_we;
  logic        tgt_we;

  logic        fwd;
  logic        l_valid;
  tag_t        l_tag;
  ctr_t        l_ctr;
  logic [31:0] l_target;
  logic        hit;
  logic        taken;

  assign ridx = bus.fetch_pc[s_index+1:2];
  assign rtag = bus.fetch_pc[PC_W-1 -: s_tag];
  assign widx = pend_word[s_index-1:0];
  assign wtag = pend_word[WORD_W-1 -: s_tag];

  // Flush FSM next state and sweep counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = {s_index{1'b0}};
    unique case (state)
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_nx = ST_FLUSH;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt == IDX_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_FLUSH;
          cnt_nx   = cnt + {{(s_index-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Write-cycle decision, evaluated against the live arrays so that
  // back-to-back updates to the same index compound.
  always_comb begin
    we     = pend_valid && (state == ST_IDLE) && !bus.flush_req;
    w_hit  = valid[widx] && (tags[widx] == wtag);
    if (w_hit) begin
      n_ctr = ctr_next(ctrs[widx], pend_taken);
    end else begin
      n_ctr = CTR_ALLOC;
    end
    arr_we = we && (w_hit || pend_taken);
    tgt_we = we && pend_taken;
  end

  // Lookup with write-through forwarding of the entry being written.
  always_comb begin
    fwd = arr_we && (widx == ridx);
    if (fwd) begin
      l_valid = 1'b1;
      l_tag   = wtag;
      l_ctr   = n_ctr;
    end else begin
      l_valid = valid[ridx];
      l_tag   = tags[ridx];
      l_ctr   = ctrs[ridx];
    end
    if (tgt_we && (widx == ridx)) begin
      l_target = pend_target;
    end else begin
      l_target = rd_target;
    end
    hit   = (state == ST_IDLE) && l_valid && (l_tag == rtag);
    taken = hit && l_ctr[1];
  end

  assign bus.pred_hit    = hit;
  assign bus.pred_taken  = taken;
  assign bus.pred_target = taken ? l_target : bus.fetch_pc + 32'd4;
  assign bus.flush_busy  = (state == ST_FLUSH);

  // Flush FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= {s_index{1'b0}};
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture resolved branches; dropped while flushing or when a flush is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_word   <= {WORD_W{1'b0}};
      pend_taken  <= 1'b0;
      pend_target <= 32'h0000_0000;
    end else begin
      pend_valid <= bus.upd_valid && (state == ST_IDLE) && !bus.flush_req;
      if (bus.upd_valid) begin
        pend_word   <= bus.upd_pc[PC_W-1:PC_OFF_W];
        pend_taken  <= bus.upd_taken;
        pend_target <= bus.upd_target;
      end
    end
  end

  // Valid/tag/counter arrays: flush sweep or write-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i] <= {s_tag{1'b0}};
        ctrs[i] <= CTR_RESET;
      end
    end else if (state == ST_FLUSH) begin
      valid[cnt] <= 1'b0;
    end else if (arr_we) begin
      valid[widx] <= 1'b1;
      tags[widx]  <= wtag;
      ctrs[widx]  <= n_ctr;
    end
  end

  btb_array #(
    .width   (32),
    .s_index (s_index)
  ) u_targets (
    .clk     (clk),
    .load    (tgt_we),
    .windex  (widx),
    .rindex  (ridx),
    .datain  (pend_target),
    .dataout (rd_target)
  );

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: the driver advances a behavioural model
// and queues the expected outputs for each cycle; a monitor compares them.
module tb_btb_predictor;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  btb_predictor_if bus ();

  btb_predictor #(.s_index(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          v;
    int unsigned tag;
    int          ctr;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    string       nm;
    bit          hit;
    bit          taken;
    logic [31:0] tgt;
    bit          busy;
  } exp_t;

  ent_t        m [N];
  bit          p_v;
  logic [31:0] p_pc;
  bit          p_t;
  logic [31:0] p_tgt;
  int          flush_left;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] d_pc, d_upc, d_utgt;
  bit          d_uv, d_ut, d_fr, d_rst;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  // Effect of one resolved branch on its entry.
  function automatic ent_t apply(ent_t e, logic [31:0] pc, bit t, logic [31:0] tg);
    if (e.v && e.tag == tag_of(pc)) begin
      if (t) begin
        e.ctr = (e.ctr == 3) ? 3 : e.ctr + 1;
        e.tgt = tg;
      end else begin
        e.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
      end
    end else if (t) begin
      e.v   = 1'b1;
      e.tag = tag_of(pc);
      e.tgt = tg;
      e.ctr = 2;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m[i].v   = 1'b0;
      m[i].tag = 0;
      m[i].ctr = 1;
      m[i].tgt = 32'h0;
    end
    p_v        = 1'b0;
    flush_left = 0;
  endtask

  // Model state change at a clock edge, using the inputs held during the cycle.
  task automatic model_edge();
    if (rst_n) begin
      if (flush_left > 0) begin
        m[N - flush_left].v = 1'b0;
        flush_left--;
        p_v = 1'b0;
      end else begin
        if (p_v && !bus.flush_req) m[idx_of(p_pc)] = apply(m[idx_of(p_pc)], p_pc, p_t, p_tgt);
        if (bus.flush_req) begin
          flush_left = N;
          p_v        = 1'b0;
        end else begin
          p_v   = bus.upd_valid;
          p_pc  = bus.upd_pc;
          p_t   = bus.upd_taken;
          p_tgt = bus.upd_target;
        end
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t        e;
    ent_t        en;
    logic [31:0] pc;
    pc      = bus.fetch_pc;
    e.nm    = "model";
    e.busy  = (flush_left > 0);
    e.hit   = 1'b0;
    e.taken = 1'b0;
    e.tgt   = pc + 32'd4;
    if (flush_left == 0) begin
      en = m[idx_of(pc)];
      if (p_v && !bus.flush_req && idx_of(p_pc) == idx_of(pc)) en = apply(en, p_pc, p_t, p_tgt);
      e.hit   = en.v && (en.tag == tag_of(pc));
      e.taken = e.hit && (en.ctr >= 2);
      if (e.taken) e.tgt = en.tgt;
    end
    return e;
  endfunction

  task automatic set_in(logic [31:0] pc, bit uv, logic [31:0] upc, bit ut, logic [31:0] utgt, bit fr);
    d_pc = pc; d_uv = uv; d_upc = upc; d_ut = ut; d_utgt = utgt; d_fr = fr;
  endtask

  task automatic step(output exp_t e);
    @(posedge clk);
    model_edge();
    #1;
    bus.fetch_pc   = d_pc;
    bus.upd_valid  = d_uv;
    bus.upd_pc     = d_upc;
    bus.upd_taken  = d_ut;
    bus.upd_target = d_utgt;
    bus.flush_req  = d_fr;
    rst_n          = d_rst;
    if (!d_rst) model_reset();
    e = predict();
  endtask

  task automatic tick();
    exp_t e;
    step(e);
    q.push_back(e);
  endtask

  task automatic tick_k(string nm, bit h, bit t, logic [31:0] tg, bit b);
    exp_t e;
    step(e);
    e.nm = nm; e.hit = h; e.taken = t; e.tgt = tg; e.busy = b;
    q.push_back(e);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    if ($urandom_range(19) == 0) p = 32'hFFFF_FFFC;
    else p = 32'($urandom_range(6, 4) * 64 + $urandom_range(15) * 4);
    if ($urandom_range(7) == 0) p[1:0] = 2'($urandom_range(3));
    return p;
  endfunction

  task automatic rand_ticks(int n, int flush_odds);
    for (int i = 0; i < n; i++) begin
      set_in(rnd_pc(), 1'($urandom_range(1)), rnd_pc(), ($urandom_range(9) < 7),
             $urandom, ($urandom_range(flush_odds - 1) == 0));
      tick();
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (bus.pred_hit !== e.hit || bus.pred_taken !== e.taken ||
            bus.pred_target !== e.tgt || bus.flush_busy !== e.busy) begin
          miscompares++;
          $display("FAIL %s @%0t: got hit=%0b taken=%0b target=%h busy=%0b, want hit=%0b taken=%0b target=%h busy=%0b",
                   e.nm, $time, bus.pred_hit, bus.pred_taken, bus.pred_target, bus.flush_busy,
                   e.hit, e.taken, e.tgt, e.busy);
        end
      end
    end
  end

  // Driver: directed scenarios, random traffic, reset during flush.
  initial begin
    rst_n = 1'b0;
    d_rst = 1'b0;
    model_reset();
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    bus.fetch_pc = 32'h100; bus.upd_valid = 1'b0; bus.upd_pc = 32'h0;
    bus.upd_taken = 1'b0; bus.upd_target = 32'h0; bus.flush_req = 1'b0;

    tick_k("reset", 1'b0, 1'b0, 32'h104, 1'b0);
    d_rst = 1'b1;
    tick_k("reset_release", 1'b0, 1'b0, 32'h104, 1'b0);

    // Allocate 0x100 -> 0x200, forwarded in the write cycle.
    set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    tick_k("alloc_present", 1'b0, 1'b0, 32'h104, 1'b0);
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick_k("alloc_forward", 1'b1, 1'b1, 32'h200, 1'b0);
    set_in(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick_k("other_tag_miss", 1'b0, 1'b0, 32'h144, 1'b0);
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick_k("alloc_stored", 1'b1, 1'b1, 32'h200, 1'b0);

    // Two back-to-back not-taken: 10 -> 01 -> 00.
    set_in(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    tick_k("nt1_present", 1'b1, 1'b1, 32'h200, 1'b0);
    tick_k("nt1_write", 1'b1, 1'b0, 32'h104, 1'b0);
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick_k("nt2_write", 1'b1, 1'b0, 32'h104, 1'b0);
    tick_k("ctr_00", 1'b1, 1'b0, 32'h104, 1'b0);

    // Four taken updates saturate at 11; one not-taken leaves 10.
    set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0);
    tick_k("t1_present", 1'b1, 1'b0, 32'h104, 1'b0);
    tick_k("t1_write_ctr01", 1'b1, 1'b0, 32'h104, 1'b0);
    tick_k("t2_write_ctr10", 1'b1, 1'b1, 32'h300, 1'b0);
    tick_k("t3_write_ctr11", 1'b1, 1'b1, 32'h300, 1'b0);
    set_in(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    tick_k("t4_write_sat", 1'b1, 1'b1, 32'h300, 1'b0);
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick_k("nt_write_ctr10", 1'b1, 1'b1, 32'h300, 1'b0);
    tick_k("still_taken", 1'b1, 1'b1, 32'h300, 1'b0);

    // Flush with an update pending: pending update discarded, 16 busy cycles.
    set_in(32'h100, 1'b1, 32'h104, 1'b1, 32'h400, 1'b0);
    tick_k("pre_flush", 1'b1, 1'b1, 32'h300, 1'b0);
    set_in(32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick_k("flush_accept", 1'b0, 1'b0, 32'h108, 1'b0);
    for (int i = 0; i < N; i++) begin
      set_in(32'h100, 1'($urandom_range(1)), 32'h100, 1'b1, 32'h500, 1'($urandom_range(1)));
      tick_k("flush_busy", 1'b0, 1'b0, 32'h104, 1'b1);
    end
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick_k("post_flush_idle", 1'b0, 1'b0, 32'h104, 1'b0);
    set_in(32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick_k("pending_dropped", 1'b0, 1'b0, 32'h108, 1'b0);

    // Random traffic against the model.
    rand_ticks(400, 40);
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (N + 2) tick();

    // Reset asserted at flush cycle 5.
    set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    tick();
    set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    tick();
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick_k("refill", 1'b1, 1'b1, 32'h200, 1'b0);
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (4) tick_k("flush_pre_reset", 1'b0, 1'b0, 32'h104, 1'b1);
    d_rst = 1'b0;
    tick_k("reset_mid_flush", 1'b0, 1'b0, 32'h104, 1'b0);
    d_rst = 1'b1;
    tick_k("reset_released", 1'b0, 1'b0, 32'h104, 1'b0);
    repeat (N + 2) tick_k("no_flush_resume", 1'b0, 1'b0, 32'h104, 1'b0);

    rand_ticks(150, 60);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 Parameter s_index, default 4, index width; entries = 2**s_index.
REQ-002 Parameter s_tag, default 32-2-s_index, tag width; tag = pc[31:s_index+2], index = pc[s_index+1:2].
REQ-003 clk  input  1  sole clock, all state on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_pc  input  32  fetch-stage PC to predict.
REQ-006 pred_hit  output  1  valid entry with matching tag for fetch_pc.
REQ-007 pred_taken  output  1  predicted taken.
REQ-008 pred_target  output  32  next fetch PC.
REQ-009 upd_valid  input  1  resolved branch from execute this cycle.
REQ-010 upd_pc  input  32  resolved branch PC.
REQ-011 upd_taken  input  1  actual outcome.
REQ-012 upd_target  input  32  actual target.
REQ-013 flush_req  input  1  one-cycle request to invalidate all entries.
REQ-014 flush_busy  output  1  high while flush in progress.

Function
REQ-015 Lookup SHALL be combinational, zero latency: pred_hit = valid[idx] && tag[idx]==fetch_pc tag && state==IDLE.
REQ-016 pred_taken SHALL equal pred_hit && counter[idx][1].
REQ-017 pred_target SHALL be stored target when pred_taken, else fetch_pc+4 (mod 2**32).
REQ-018 upd_valid SHALL be captured into a one-entry update register at posedge; entry state SHALL be written at the following posedge (write cycle).
REQ-019 In the write cycle, hit/counter SHALL be evaluated from the current valid/tag/counter arrays, so back-to-back updates to one index compound correctly.
REQ-020 Update hit: counter saturating +1 if taken (max 2'b11), -1 if not (min 2'b00); target overwritten only if taken.
REQ-021 Update miss and taken: allocate — valid=1, tag written, target written, counter=2'b10.
REQ-022 Update miss and not taken: no array write.
REQ-023 Lookup of the index being written in the write cycle SHALL return the new target, tag, valid and counter (write-through forwarding).
REQ-024 FSM states IDLE, FLUSH; IDLE->FLUSH on flush_req; FLUSH clears valid[cnt] with cnt 0..entries-1, one per cycle; FLUSH->IDLE after clearing entries-1; flush lasts exactly entries cycles.
REQ-025 flush_busy SHALL be 1 iff state==FLUSH.
REQ-026 In FLUSH: pred_hit=0, upd_valid ignored, flush_req ignored.
REQ-027 An update held in the update register when flush_req is accepted SHALL be discarded.
REQ-028 flush_req and upd_valid in the same IDLE cycle: flush wins, update dropped.

Reset
REQ-029 rst_n low SHALL immediately force: all valid=0, all counters=2'b01, state IDLE, cnt 0, update register empty.
REQ-030 During and after reset until a write: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4, flush_busy=0.
REQ-031 Target storage SHALL NOT be reset; its contents are don't-care while valid=0.
REQ-032 Reset asserted mid-flush or with an update pending SHALL abort it; nothing completes after deassertion.

Structure
REQ-033 Shared package: FSM state enum, counter type, counter constants (2'b01 reset, 2'b10 allocate), index/tag extraction widths.
REQ-034 Valid, tag, counter arrays SHALL be resettable flops in this block.
REQ-035 Target storage SHALL be one btb_array instance (width 32, rindex=fetch idx, windex=update idx, load=write-cycle taken write).

Verification
REQ-036 Reset, fetch_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-037 upd pc=0x100 taken target=0x200 at edge N -> from cycle after N, fetch 0x100 gives hit=1, taken=1, target=0x200 (forwarded); fetch 0x140 (same idx, other tag) gives hit=0.
REQ-038 Two back-to-back not-taken updates to 0x100 after allocate -> counter 10->01->00; pred_taken=0, pred_target=0x104, hit=1.
REQ-039 Four consecutive taken updates to 0x100 -> counter saturates at 11; one not-taken -> 10, still taken.
REQ-040 flush_req with 16 entries and pending update -> flush_busy high exactly 16 cycles, pred_hit=0 throughout, all lookups miss after, pending update absent.
REQ-041 rst_n low at flush cycle 5 -> flush_busy=0 immediately, all valid=0 after deassertion.
